mux414_arbiter: RTL and testbench
=================================

# mux414_arbiter

Round-robin arbiter sharing the 4-bit, 4-way multiplexed datapath among four requesters. It grants one requester at a time and drives the 2-bit select of the `MUX414` data mux. It presents a valid/ready handshake toward the downstream consumer and enforces a maximum burst length per grant, so no requester can starve the others. It sits between the four 4-bit symbol sources and the shared mux feeding the downstream stage.

## Interface
- `MAX_BURST`, default 8: maximum accepted beats per grant; legal range 1..255.
- `inClk`  in  1  single clock; all state updates on rising edge.
- `inRst`  in  1  synchronous, active-high reset.
- `inReq`  in  4  request per requester; bit i = requester i has a beat available.
- `inReady`  in  1  downstream accepts the current beat.
- `outGnt`  out  4  one-hot grant; all zero when idle.
- `outSel`  out  2  index of the granted requester, to the mux select.
- `outValid`  out  1  granted requester is presenting a beat this cycle.
- `outBurstEnd`  out  1  one-cycle pulse on the cycle the grant is released.

## Operation
- FSM states: `IDLE`, `GRANT`.
- `IDLE`: if `inReq != 0`, pick a winner by round-robin starting at pointer `ptr` (search order `ptr`, `ptr+1`, … mod 4). At the edge: register `outGnt` to the winner's one-hot, `outSel` to the winner's index, and `cnt` to 0, then go to `GRANT`. If `inReq == 0`, stay in `IDLE`.
- `GRANT`, granted index g:
  - `outValid = inReq[g]`, combinational from the state and `inReq`.
  - A beat is accepted when `outValid && inReady`; `cnt` increments on each accepted beat.
- Release conditions in `GRANT`, evaluated each cycle:
  - (a) `inReq[g] == 0`; or
  - (b) a beat is accepted while `cnt == MAX_BURST-1`.
- On release:
  - `outBurstEnd = 1` that cycle.
  - At the edge: `ptr` is set to (g+1) mod 4, `outGnt` clears, and the FSM goes to `IDLE`.
- `outSel` holds the last granted index while in `IDLE`, which keeps the mux stable; it changes only when a new grant is registered.
- `cnt` is 8 bits wide and never exceeds `MAX_BURST-1`.
- With `MAX_BURST = 1`, every accepted beat releases the grant.
- Simultaneous events:
  - If (a) and (b) are both true in the same cycle, it is a single release with one `outBurstEnd` pulse.
  - `inReady` high while `outValid` is low counts nothing.
  - Requests from non-granted requesters are ignored until the FSM returns to `IDLE`.
- Reset, including mid-burst: state `IDLE`, `ptr = 0`, `cnt = 0`, `outGnt = 0`, `outSel = 0`, `outValid = 0`, `outBurstEnd = 0`. Any partial burst is abandoned with no pulse.

## Timing
- Grant latency: request high in `IDLE` at cycle N gives `outGnt`/`outSel` valid at N+1, and the first beat is acceptable at N+1.
- Release at cycle M gives `outGnt = 0` at M+1 (the `IDLE` bubble), and the next grant appears at M+2 at the earliest.
- The throughput of a single continuously requesting requester with `inReady` held high is therefore `MAX_BURST` beats per `MAX_BURST+1` cycles.
- `outValid` and `outBurstEnd` are combinational from registered state plus `inReq`/`inReady`. There is no combinational path from `inReq` to `outGnt` or `outSel`.
- `outGnt` is always one-hot or zero, and `outSel` always equals the index of the set bit whenever `outGnt != 0`.

## Structure
- Package `mux_arb_pkg`:
  - `NUM_REQ = 4`
  - `SEL_W = 2`
  - state enum `arb_state_t {IDLE, GRANT}`
- Sub-module `rr_pick4`: purely combinational. Inputs are `inReq[3:0]` and `ptr[1:0]`; outputs are the winner index, the winner one-hot, and an any-request flag. It is instanced once in `IDLE` arbitration.
- The top level holds the FSM, `ptr`, `cnt`, and the output registers.

## Test plan
- Reset then single requester: `inReq = 4'b0100` at cycle 1 and `inReady = 1` → `outGnt = 4'b0100` and `outSel = 2` at cycle 2. Eight beats are accepted in cycles 2–9, `outBurstEnd` pulses at cycle 9, `outGnt = 0` at cycle 10, and the re-grant to 2 appears at cycle 11.
- Fairness: `inReq = 4'b1111` held, `inReady = 1`, `MAX_BURST = 2` → grant order is 0, 1, 2, 3, 0. Each grant has exactly 2 `outValid` beats followed by a one-cycle idle gap.
- Early drop: requester 1 is granted, and `inReq[1]` falls after 3 accepted beats → `outBurstEnd` pulses that cycle with `cnt = 3`. The next grant then goes to the next requesting index after 1 (e.g. 3 if only `inReq[3]` is set).
- Backpressure: requester 0 granted, `MAX_BURST = 4`, `inReady` toggling 1,0,1,0,… → `cnt` advances only on ready cycles, and release occurs on the 4th accepted beat (cycle 7 after the grant).
- Reset mid-burst: `inRst` asserted while in `GRANT` with `cnt = 5` → the next cycle has all outputs zero and no `outBurstEnd`. With `inReq = 4'b1010` after reset, the first grant goes to 1 (`ptr = 0`).
- Simultaneous release: the last beat is accepted in the same cycle that `inReq[g]` drops → exactly one `outBurstEnd` pulse is produced.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and sizes for the four-way round-robin mux arbiter.
package mux_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/mux414_arbiter_rr_pick4.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod 4.
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   win_idx,
  output logic [NUM_REQ-1:0] win_gnt,
  output logic               any_req
);

  logic found;

  always_comb begin
    logic [SEL_W-1:0] cand;
    found   = 1'b0;
    win_idx = ptr;
    cand    = ptr;
    any_req = |req;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    win_gnt = any_req ? (NUM_REQ'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/mux414_arbiter.sv
// Round-robin arbiter for the shared 4x4-bit mux with per-grant burst limit.
//
// state | meaning
// IDLE  | no grant; arbitrate among requests starting at ptr
// GRANT | one requester owns the mux until it drops or hits MAX_BURST beats
module mux414_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic               inClk,
  input  logic               inRst,
  input  logic [NUM_REQ-1:0] inReq,
  input  logic               inReady,
  output logic [NUM_REQ-1:0] outGnt,
  output logic [SEL_W-1:0]   outSel,
  output logic               outValid,
  output logic               outBurstEnd
);

  localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

  arb_state_t         state;
  logic [SEL_W-1:0]   ptr;
  logic [7:0]         cnt;

  logic [SEL_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_gnt;
  logic               any_req;
  logic               accept;
  logic               release_gnt;

  rr_pick4 u_pick (
    .req     (inReq),
    .ptr     (ptr),
    .win_idx (win_idx),
    .win_gnt (win_gnt),
    .any_req (any_req)
  );

  // outSel holds the granted index for the whole of GRANT, so it doubles as g.
  assign outValid    = (state == GRANT) && inReq[outSel];
  assign accept      = outValid && inReady;
  assign release_gnt = (state == GRANT) &&
                       (!inReq[outSel] || (accept && (cnt == LAST_CNT)));
  assign outBurstEnd = release_gnt;

  always_ff @(posedge inClk) begin
    if (inRst) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      outGnt <= '0;
      outSel <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            outGnt <= win_gnt;
            outSel <= win_idx;
            cnt    <= '0;
            state  <= GRANT;
          end
        end
        GRANT: begin
          if (release_gnt) begin
            ptr    <= outSel + SEL_W'(1);
            outGnt <= '0;
            state  <= IDLE;
          end else if (accept) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux414_arbiter.sv
// Directed bench for mux414_arbiter: per-cycle vector table plus short burst-limit sequences.
module tb_mux414_arbiter;

  logic       inClk = 1'b0;
  logic       inRst;
  logic [3:0] inReq;
  logic       inReady;

  logic [3:0] g1, g2, g4, g8;
  logic [1:0] s1, s2, s4, s8;
  logic       v1, v2, v4, v8;
  logic       b1, b2, b4, b8;

  int n_vec = 0;
  int n_bad = 0;

  always #5 inClk = ~inClk;

  mux414_arbiter #(.MAX_BURST(1)) dut1 (.inClk(inClk), .inRst(inRst), .inReq(inReq), .inReady(inReady),
    .outGnt(g1), .outSel(s1), .outValid(v1), .outBurstEnd(b1));
  mux414_arbiter #(.MAX_BURST(2)) dut2 (.inClk(inClk), .inRst(inRst), .inReq(inReq), .inReady(inReady),
    .outGnt(g2), .outSel(s2), .outValid(v2), .outBurstEnd(b2));
  mux414_arbiter #(.MAX_BURST(4)) dut4 (.inClk(inClk), .inRst(inRst), .inReq(inReq), .inReady(inReady),
    .outGnt(g4), .outSel(s4), .outValid(v4), .outBurstEnd(b4));
  mux414_arbiter #(.MAX_BURST(8)) dut8 (.inClk(inClk), .inRst(inRst), .inReq(inReq), .inReady(inReady),
    .outGnt(g8), .outSel(s8), .outValid(v8), .outBurstEnd(b8));

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic       chk;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       bend;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, input logic [3:0] req, input logic rdy, input logic chk,
                              input logic [3:0] gnt, input logic [1:0] sel, input logic valid, input logic bend);
    vec_t v;
    v.rst = rst; v.req = req; v.rdy = rdy; v.chk = chk;
    v.gnt = gnt; v.sel = sel; v.valid = valid; v.bend = bend;
    tbl.push_back(v);
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
  task automatic drive(input logic rst, input logic [3:0] req, input logic rdy);
    inRst = rst; inReq = req; inReady = rdy;
    #4;
  endtask

  task automatic tick();
    @(posedge inClk);
    #1;
  endtask

  task automatic check(input string nm, input int idx,
                       input logic [3:0] ag, input logic [1:0] as, input logic av, input logic ab,
                       input logic [3:0] eg, input logic [1:0] es, input logic ev, input logic eb);
    n_vec++;
    if ({ag, as, av, ab} !== {eg, es, ev, eb}) begin
      n_bad++;
      $display("FAIL %s[%0d]: got gnt=%b sel=%0d valid=%b bend=%b, want gnt=%b sel=%0d valid=%b bend=%b",
               nm, idx, ag, as, av, ab, eg, es, ev, eb);
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 4'b0000, 1'b0);
    tick();
  endtask

  initial begin
    inRst = 1'b1; inReq = '0; inReady = 1'b0;
    @(posedge inClk);
    #1;

    // MAX_BURST=8: full burst, re-grant, early drop, reset mid-burst, last beat then drop.
    add(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0100, 1, 1, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 4'b0100, 1, 1, 4'b0100, 2, 1, 0);
    add(0, 4'b0100, 1, 1, 4'b0100, 2, 1, 1);
    add(0, 4'b0100, 1, 1, 4'b0000, 2, 0, 0);
    add(0, 4'b0100, 1, 1, 4'b0100, 2, 1, 0);
    add(0, 4'b0000, 1, 1, 4'b0100, 2, 0, 1);
    add(0, 4'b0000, 1, 1, 4'b0000, 2, 0, 0);
    add(0, 4'b0010, 1, 1, 4'b0000, 2, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 4'b0010, 1, 1, 4'b0010, 1, 1, 0);
    add(0, 4'b1000, 1, 1, 4'b0010, 1, 0, 1);
    add(0, 4'b1000, 1, 1, 4'b0000, 1, 0, 0);
    add(0, 4'b1010, 0, 1, 4'b1000, 3, 1, 0);
    add(0, 4'b0010, 1, 1, 4'b1000, 3, 0, 1);
    add(0, 4'b0001, 1, 1, 4'b0000, 3, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 4'b0001, 1, 1, 4'b0001, 0, 1, 0);
    add(1, 4'b0001, 1, 1, 4'b0001, 0, 1, 0);
    add(0, 4'b1010, 1, 1, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 4'b1010, 1, 1, 4'b0010, 1, 1, 0);
    add(0, 4'b1010, 1, 1, 4'b0010, 1, 1, 1);
    add(0, 4'b1000, 1, 1, 4'b0000, 1, 0, 0);
    add(0, 4'b1000, 1, 1, 4'b1000, 3, 1, 0);
    add(0, 4'b0000, 1, 1, 4'b1000, 3, 0, 1);
    add(0, 4'b0000, 1, 1, 4'b0000, 3, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].rdy);
      if (tbl[i].chk)
        check("table", i, g8, s8, v8, b8, tbl[i].gnt, tbl[i].sel, tbl[i].valid, tbl[i].bend);
      tick();
    end

    // MAX_BURST=2, all requesting: grants rotate 0,1,2,3,0 with 2 beats and a 1-cycle gap.
    do_reset();
    drive(1'b0, 4'b1111, 1'b1);
    check("fair_idle", 0, g2, s2, v2, b2, 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      logic [1:0] idx;
      logic [3:0] oh;
      idx = 2'(k % 4);
      oh  = 4'b0001 << idx;
      drive(1'b0, 4'b1111, 1'b1);
      check("fair_beat1", k, g2, s2, v2, b2, oh, idx, 1'b1, 1'b0);
      tick();
      drive(1'b0, 4'b1111, 1'b1);
      check("fair_beat2", k, g2, s2, v2, b2, oh, idx, 1'b1, 1'b1);
      tick();
      drive(1'b0, 4'b1111, 1'b1);
      check("fair_gap", k, g2, s2, v2, b2, 4'b0000, idx, 1'b0, 1'b0);
      tick();
    end

    // MAX_BURST=4 with ready toggling: release on the 4th accepted beat, 7th granted cycle.
    do_reset();
    drive(1'b0, 4'b0001, 1'b1);
    check("bp_idle", 0, g4, s4, v4, b4, 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    for (int o = 0; o < 7; o++) begin
      drive(1'b0, 4'b0001, (o % 2) == 0);
      check("bp_beat", o, g4, s4, v4, b4, 4'b0001, 2'd0, 1'b1, o == 6);
      tick();
    end
    drive(1'b0, 4'b0000, 1'b1);
    check("bp_after", 0, g4, s4, v4, b4, 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();

    // MAX_BURST=1: each accepted beat releases; a stalled beat holds the grant.
    do_reset();
    drive(1'b0, 4'b0100, 1'b1);
    check("mb1_idle", 0, g1, s1, v1, b1, 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'b0100, 1'b1);
    check("mb1_beat", 0, g1, s1, v1, b1, 4'b0100, 2'd2, 1'b1, 1'b1);
    tick();
    drive(1'b0, 4'b0100, 1'b0);
    check("mb1_gap", 0, g1, s1, v1, b1, 4'b0000, 2'd2, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'b0100, 1'b0);
    check("mb1_stall", 0, g1, s1, v1, b1, 4'b0100, 2'd2, 1'b1, 1'b0);
    tick();
    drive(1'b0, 4'b0100, 1'b1);
    check("mb1_beat", 1, g1, s1, v1, b1, 4'b0100, 2'd2, 1'b1, 1'b1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
